// File: rtl/fifo_rd_packer_if.sv
// Signal bundle between fifo_rd_packer, the async byte FIFO read port and the
// downstream word stream. The master modport is the packer side; slave is the environment side.
interface fifo_rd_packer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int PACK       = 4
) ();
    localparam int BCNT_W = $clog2(PACK) + 1;

    // FIFO read port
    logic                       fifo_empty;
    logic [DATA_WIDTH-1:0]      fifo_data;
    logic                       fifo_rd_enb;

    // Flush request
    logic                       flush;

    // Packed word stream
    logic                       m_valid;
    logic                       m_ready;
    logic [PACK*DATA_WIDTH-1:0] m_data;
    logic [BCNT_W-1:0]          m_bcnt;
    logic                       m_last;

    modport master (
        input  fifo_empty,
        input  fifo_data,
        output fifo_rd_enb,
        input  flush,
        output m_valid,
        input  m_ready,
        output m_data,
        output m_bcnt,
        output m_last
    );

    modport slave (
        output fifo_empty,
        output fifo_data,
        input  fifo_rd_enb,
        output flush,
        input  m_valid,
        output m_ready,
        input  m_data,
        input  m_bcnt,
        input  m_last
    );
endinterface

// File: rtl/fifo_rd_packer.sv
// Read-domain packer: pops bytes from the async FIFO and emits PACK-byte little-endian words.
// Optional idle auto-flush is compiled in with the macro FIFO_RD_TIMEOUT_EN.
module fifo_rd_packer #(
    parameter int DATA_WIDTH = 8,
    parameter int PACK       = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic             rd_clk,
    input  logic             rstn,
    fifo_rd_packer_if.master bus
);
    localparam int BCNT_W = $clog2(PACK) + 1;
    localparam int WORD_W = PACK * DATA_WIDTH;

    localparam logic [BCNT_W-1:0] CNT_FULL  = BCNT_W'(PACK);
    localparam logic [BCNT_W:0]   OCC_LIMIT = (BCNT_W + 1)'(PACK);

    if (PACK < 2 || PACK > 8 || TIMEOUT < 2) begin : g_bad_cfg
        $error("fifo_rd_packer: PACK must be 2..8 and TIMEOUT at least 2");
    end

    typedef enum logic [0:0] {
        ST_ACCUM = 1'b0,
        ST_DRAIN = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [WORD_W-1:0]   acc_q, acc_d;
    logic [BCNT_W-1:0]   cnt_q, cnt_d;
    logic                rd_enb_q, rd_enb_d;
    logic                m_valid_q, m_valid_d;
    logic [WORD_W-1:0]   m_data_q, m_data_d;
    logic [BCNT_W-1:0]   m_bcnt_q, m_bcnt_d;
    logic                m_last_q, m_last_d;

    logic                flush_req_s;
    logic                pend_s;
    logic                slot_free_s;
    logic                cnt_full_s;
    logic                cnt_zero_s;
    logic                xfer_s;
    logic                last_s;
    logic                drain_done_s;
    logic [BCNT_W-1:0]   cnt_eff_s;
    logic [BCNT_W:0]     occ_s;
    logic [WORD_W-1:0]   acc_base_s;

`ifdef FIFO_RD_TIMEOUT_EN
    localparam int              TO_W     = $clog2(TIMEOUT);
    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT - 1);

    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            to_arm_s;
    logic            to_hit_s;

    // Idle timer: runs only while a partial word sits with nothing left to fetch
    always_comb begin
        to_arm_s = (cnt_q != {BCNT_W{1'b0}}) && !rd_enb_q && bus.fifo_empty
                   && (state_q == ST_ACCUM);
        to_hit_s = 1'b0;
        to_cnt_d = {TO_W{1'b0}};
        if (to_arm_s) begin
            if (to_cnt_q == TO_LIMIT) begin
                to_hit_s = 1'b1;
                to_cnt_d = {TO_W{1'b0}};
            end else begin
                to_cnt_d = to_cnt_q + {{(TO_W-1){1'b0}}, 1'b1};
            end
        end else begin
            to_cnt_d = {TO_W{1'b0}};
        end
    end

    // Idle timer register
    always_ff @(posedge rd_clk or negedge rstn) begin
        if (!rstn) begin
            to_cnt_q <= {TO_W{1'b0}};
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end

    assign flush_req_s = bus.flush | to_hit_s;
`else
    assign flush_req_s = bus.flush;
`endif

    // Control: word transfer decision and next-cycle pop request
    always_comb begin
        pend_s      = (state_q == ST_DRAIN) || flush_req_s;
        slot_free_s = !m_valid_q || bus.m_ready;
        cnt_full_s  = (cnt_q == CNT_FULL);
        cnt_zero_s  = (cnt_q == {BCNT_W{1'b0}});

        // A partial word may only leave once the last in-flight byte has landed
        if (!slot_free_s) begin
            xfer_s = 1'b0;
        end else if (cnt_full_s) begin
            xfer_s = 1'b1;
        end else begin
            xfer_s = pend_s && !rd_enb_q && !cnt_zero_s;
        end

        last_s       = pend_s && !rd_enb_q;
        drain_done_s = last_s && (cnt_zero_s || xfer_s);

        if (xfer_s) begin
            cnt_eff_s = {BCNT_W{1'b0}};
        end else begin
            cnt_eff_s = cnt_q;
        end

        occ_s    = {1'b0, cnt_eff_s} + {{BCNT_W{1'b0}}, rd_enb_q};
        rd_enb_d = !bus.fifo_empty && !pend_s && (occ_s < OCC_LIMIT);
    end

    // Accumulator: clear on transfer, drop a captured byte into lane cnt
    always_comb begin
        if (xfer_s) begin
            acc_base_s = {WORD_W{1'b0}};
        end else begin
            acc_base_s = acc_q;
        end
        acc_d = acc_base_s;
        for (int k = 0; k < PACK; k++) begin
            acc_d[k*DATA_WIDTH +: DATA_WIDTH] =
                (rd_enb_q && (cnt_eff_s == BCNT_W'(k))) ? bus.fifo_data
                                                        : acc_base_s[k*DATA_WIDTH +: DATA_WIDTH];
        end
        cnt_d = cnt_eff_s + {{(BCNT_W-1){1'b0}}, rd_enb_q};
    end

    // Output slot: load on transfer, release on acceptance, otherwise hold
    always_comb begin
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_bcnt_d  = m_bcnt_q;
        m_last_d  = m_last_q;
        if (xfer_s) begin
            m_valid_d = 1'b1;
            m_data_d  = acc_q;
            m_bcnt_d  = cnt_q;
            m_last_d  = last_s;
        end else if (m_valid_q && bus.m_ready) begin
            m_valid_d = 1'b0;
        end else begin
            m_valid_d = m_valid_q;
        end
    end

    // Flush FSM: DRAIN blocks pops until the partial word has been emitted
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ACCUM: begin
                if (flush_req_s && !drain_done_s) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_ACCUM;
                end
            end
            ST_DRAIN: begin
                if (drain_done_s) begin
                    state_d = ST_ACCUM;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: state_d = ST_ACCUM;
        endcase
    end

    // State registers
    always_ff @(posedge rd_clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ST_ACCUM;
            acc_q     <= {WORD_W{1'b0}};
            cnt_q     <= {BCNT_W{1'b0}};
            rd_enb_q  <= 1'b0;
            m_valid_q <= 1'b0;
            m_data_q  <= {WORD_W{1'b0}};
            m_bcnt_q  <= {BCNT_W{1'b0}};
            m_last_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            rd_enb_q  <= rd_enb_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_bcnt_q  <= m_bcnt_d;
            m_last_q  <= m_last_d;
        end
    end

    assign bus.fifo_rd_enb = rd_enb_q;
    assign bus.m_valid     = m_valid_q;
    assign bus.m_data      = m_data_q;
    assign bus.m_bcnt      = m_bcnt_q;
    assign bus.m_last      = m_last_q;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Scoreboard bench for fifo_rd_packer: a byte FIFO model feeds the packer, expected words are
// queued as bytes are pushed and compared as the DUT hands them off.
module tb_fifo_rd_packer;
    localparam int DW = 8;
    localparam int PK = 4;
    localparam int TO = 16;

    logic rd_clk = 1'b0;
    logic rstn   = 1'b0;

    always #5 rd_clk = ~rd_clk;

    fifo_rd_packer_if #(.DATA_WIDTH(DW), .PACK(PK)) bus ();

    fifo_rd_packer #(.DATA_WIDTH(DW), .PACK(PK), .TIMEOUT(TO)) dut (
        .rd_clk (rd_clk),
        .rstn   (rstn),
        .bus    (bus)
    );

    typedef struct packed {
        logic [31:0] data;
        logic [2:0]  bcnt;
        logic        last;
    } word_t;

    word_t       exp_q[$];
    int          acc_cyc[$];
    int          n_cmp      = 0;
    int          n_bad      = 0;
    int          cyc        = 0;
    int          wr_ptr     = 0;
    int          rd_ptr     = 0;
    int          pop_cnt    = 0;
    int          underflow  = 0;
    int          valid_seen = 0;
    int          hold_viol  = 0;
    int          part_n     = 0;
    logic [31:0] part       = 32'h0;
    logic [7:0]  mem [0:255];
    int          occ;

    // FIFO model: a pop already requested counts against occupancy
    assign occ            = wr_ptr - rd_ptr;
    assign bus.fifo_empty = (occ <= (bus.fifo_rd_enb ? 1 : 0));
    assign bus.fifo_data  = mem[rd_ptr[7:0]];

    always @(posedge rd_clk) begin
        cyc <= cyc + 1;
        if (bus.fifo_rd_enb) begin
            pop_cnt <= pop_cnt + 1;
            if (occ == 0) underflow <= underflow + 1;
            else          rd_ptr    <= rd_ptr + 1;
        end
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        mem[wr_ptr[7:0]] = b;
        wr_ptr++;
        part[part_n*8 +: 8] = b;
        part_n++;
        if (part_n == PK) begin
            exp_q.push_back('{data: part, bcnt: 3'd4, last: 1'b0});
            part   = 32'h0;
            part_n = 0;
        end
    endtask

    task automatic expect_partial_last();
        if (part_n > 0) begin
            exp_q.push_back('{data: part, bcnt: part_n[2:0], last: 1'b1});
            part   = 32'h0;
            part_n = 0;
        end
    endtask

    task automatic pulse_flush();
        expect_partial_last();
        bus.flush = 1'b1;
        @(negedge rd_clk);
        bus.flush = 1'b0;
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge rd_clk);
            n++;
        end
        check_val({tag, "_drain"}, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check_val({tag, "_rd_enb"},  64'(bus.fifo_rd_enb), 64'd0);
        check_val({tag, "_m_valid"}, 64'(bus.m_valid),     64'd0);
        check_val({tag, "_m_data"},  64'(bus.m_data),      64'd0);
        check_val({tag, "_m_bcnt"},  64'(bus.m_bcnt),      64'd0);
        check_val({tag, "_m_last"},  64'(bus.m_last),      64'd0);
    endtask

    initial begin
        int          p0;
        int          t0;
        logic        hold_prev;
        logic [35:0] hold_data;
        word_t       w;

        bus.flush   = 1'b0;
        bus.m_ready = 1'b0;
        hold_prev   = 1'b0;
        hold_data   = 36'h0;

        // Monitor: samples after the negedge input updates, well before the next posedge
        fork
            forever begin
                @(negedge rd_clk);
                #2;
                if (!rstn) begin
                    hold_prev = 1'b0;
                end else begin
                    if (bus.m_valid) valid_seen++;
                    if (hold_prev && {bus.m_last, bus.m_bcnt, bus.m_data} !== hold_data)
                        hold_viol++;
                    hold_prev = bus.m_valid && !bus.m_ready;
                    hold_data = {bus.m_last, bus.m_bcnt, bus.m_data};
                    if (bus.m_valid && bus.m_ready) begin
                        acc_cyc.push_back(cyc);
                        if (exp_q.size() == 0) begin
                            check_val("unexpected_word_pending", 64'(exp_q.size()), 64'd1);
                        end else begin
                            w = exp_q.pop_front();
                            check_val("m_data", 64'(bus.m_data), 64'(w.data));
                            check_val("m_bcnt", 64'(bus.m_bcnt), 64'(w.bcnt));
                            check_val("m_last", 64'(bus.m_last), 64'(w.last));
                        end
                    end
                end
            end
        join_none

        // Reset state
        repeat (3) @(negedge rd_clk);
        check_outputs_zero("reset");
        rstn = 1'b1;
        repeat (2) @(negedge rd_clk);

        // One full word, four pops, first-word latency
        bus.m_ready = 1'b1;
        p0 = pop_cnt;
        acc_cyc.delete();
        t0 = cyc;
        push_byte(8'h11); push_byte(8'h22); push_byte(8'h33); push_byte(8'h44);
        wait_drain("word1", 40);
        repeat (4) @(negedge rd_clk);
        check_val("word1_pops", 64'(pop_cnt - p0), 64'd4);
        if (acc_cyc.size() > 0) check_val("first_latency", 64'(acc_cyc[0] - t0), 64'd6);
        else                    check_val("first_latency_seen", 64'(acc_cyc.size()), 64'd1);

        // Back-to-back words, one bubble per word
        acc_cyc.delete();
        for (int i = 1; i <= 8; i++) push_byte(8'(i));
        wait_drain("b2b", 60);
        if (acc_cyc.size() == 2) check_val("b2b_spacing", 64'(acc_cyc[1] - acc_cyc[0]), 64'd5);
        else                     check_val("b2b_words", 64'(acc_cyc.size()), 64'd2);

        // Backpressure: first word held, reads stall with second word complete
        repeat (3) @(negedge rd_clk);
        bus.m_ready = 1'b0;
        hold_viol   = 0;
        p0 = pop_cnt;
        for (int i = 0; i < 8; i++) push_byte(8'h80 + 8'(i));
        repeat (20) @(negedge rd_clk);
        check_val("bp_valid",  64'(bus.m_valid),     64'd1);
        check_val("bp_data",   64'(bus.m_data),      64'h83828180);
        check_val("bp_rd_enb", 64'(bus.fifo_rd_enb), 64'd0);
        check_val("bp_pops",   64'(pop_cnt - p0),    64'd8);
        bus.m_ready = 1'b1;
        wait_drain("bp", 40);
        check_val("bp_hold_stable", 64'(hold_viol), 64'd0);

        // Partial word through flush, then flush with nothing accumulated
        push_byte(8'hA1); push_byte(8'hB2); push_byte(8'hC3);
        repeat (10) @(negedge rd_clk);
        pulse_flush();
        wait_drain("flush3", 40);
        repeat (3) @(negedge rd_clk);
        valid_seen = 0;
        pulse_flush();
        repeat (10) @(negedge rd_clk);
        check_val("flush_empty_no_valid", 64'(valid_seen), 64'd0);

        // Asynchronous reset mid-word
        bus.m_ready = 1'b0;
        for (int i = 0; i < 6; i++) push_byte(8'h40 + 8'(i));
        repeat (8) @(negedge rd_clk);
        check_val("pre_reset_valid", 64'(bus.m_valid), 64'd1);
        #3;
        rstn = 1'b0;
        #1;
        check_outputs_zero("async_reset");
        exp_q.delete();
        part   = 32'h0;
        part_n = 0;
        repeat (2) @(negedge rd_clk);
        rstn        = 1'b1;
        bus.m_ready = 1'b1;
        @(negedge rd_clk);
        push_byte(8'h61); push_byte(8'h62); push_byte(8'h63); push_byte(8'h64);
        wait_drain("post_reset", 40);

        // Lone byte with an idle FIFO
        repeat (3) @(negedge rd_clk);
`ifdef FIFO_RD_TIMEOUT_EN
        acc_cyc.delete();
        t0 = cyc;
        push_byte(8'h5A);
        expect_partial_last();
        wait_drain("timeout", 80);
        if (acc_cyc.size() > 0)
            check_val("timeout_latency_window",
                      64'((acc_cyc[0] - t0 >= TO) && (acc_cyc[0] - t0 <= TO + 8)), 64'd1);
        else
            check_val("timeout_word_seen", 64'(acc_cyc.size()), 64'd1);
`else
        valid_seen = 0;
        push_byte(8'h5A);
        repeat (40) @(negedge rd_clk);
        check_val("idle_no_autoflush", 64'(valid_seen), 64'd0);
        pulse_flush();
        wait_drain("idle_flush", 40);
`endif

        repeat (5) @(negedge rd_clk);
        check_val("no_underflow", 64'(underflow), 64'd0);
        check_val("end_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
